// File: rtl/cpu_pkg.sv
// Shared GRF write-back types: request record and the LU write-port arbiter states.
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} arb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests holding LU results until the GRF port is free.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t head,
  output logic    full,
  output logic    empty,
  output logic    last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  assign head  = mem[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign last  = (count_q == CW'(1));
endmodule

// File: rtl/grf_wb_scheduler.sv
// Arbitrates the single GRF write port between the W stage and queued LU results,
// and keeps the pending-destination scoreboard that stalls issue on RAW/WAW hazards.
module grf_wb_scheduler
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs,
  input  logic [REG_AW-1:0] iss_rt,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_long,
  output logic              iss_stall,
  input  logic              w_we,
  input  logic [REG_AW-1:0] w_wa,
  input  logic [DATA_W-1:0] w_wd,
  input  logic [DATA_W-1:0] w_pc,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_wa,
  input  logic [DATA_W-1:0] lu_wd,
  input  logic [DATA_W-1:0] lu_pc,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_wa,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc
);
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

  arb_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] busy_q, busy_d;

  wb_req_t head;
  logic fifo_full, fifo_empty, fifo_last;
  logic w_active, drain, push, empty_after, hazard, issue_set;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (drain),
    .din   ('{wa: lu_wa, wd: lu_wd, pc: lu_pc}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last)
  );

  assign w_active    = w_we && (w_wa != '0);
  assign drain       = !reset && !w_active && !fifo_empty;
  assign lu_ready    = !reset && !fifo_full;
  // Writes to r0 are handshaken but never stored.
  assign push        = lu_valid && lu_ready && (lu_wa != '0);
  assign empty_after = fifo_last && !push;

  assign grf_we = !reset && (w_active || !fifo_empty);
  always_comb begin
    grf_wa = w_wa;
    grf_wd = w_wd;
    grf_pc = w_pc;
    if (!w_active && !fifo_empty) begin
      grf_wa = head.wa;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end
  end

  // Registered busy: a register draining this cycle still stalls for one bubble.
  assign hazard    = busy_q[iss_rs] | busy_q[iss_rt] | busy_q[iss_rd];
  assign iss_stall = !reset && ((iss_valid && hazard) || (state_q == FORCE));
  assign issue_set = iss_valid && !iss_stall && iss_long && (iss_rd != '0);

  always_comb begin
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (drain)     busy_d[head.wa] = 1'b0;
    if (issue_set) busy_d[iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (drain) begin
          state_d = empty_after ? IDLE : WAIT;
          cnt_d   = '0;
        end else if (w_active) begin
          if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = FORCE;
          else                                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      FORCE: begin
        if (drain) begin
          state_d = empty_after ? IDLE : WAIT;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The scoreboard must keep the W stage off registers still owed by the LU.
  a_no_w_on_busy: assert property (@(posedge clk) disable iff (reset)
    !(w_active && busy_q[w_wa]));
endmodule

// File: tb/tb_grf_wb_scheduler.sv
// Directed bench for grf_wb_scheduler: arbitration, scoreboard stalls, starvation and reset.
module tb_grf_wb_scheduler;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_long, iss_stall;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        w_we;
  logic [4:0]  w_wa;
  logic [31:0] w_wd, w_pc;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd, lu_pc;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd, grf_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grf_wb_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
    .iss_long(iss_long), .iss_stall(iss_stall),
    .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_pc(w_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_pc(lu_pc),
    .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0; iss_long = 0;
    w_we = 0; w_wa = 0; w_wd = 0; w_pc = 0;
    lu_valid = 0; lu_wa = 0; lu_wd = 0; lu_pc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic iss(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic lng);
    iss_valid = 1; iss_rs = rs; iss_rt = rt; iss_rd = rd; iss_long = lng;
  endtask

  task automatic wdrv(input logic [4:0] wa, input logic [31:0] wd);
    w_we = 1; w_wa = wa; w_wd = wd; w_pc = 32'h1000 + wd;
  endtask

  task automatic lu(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    lu_valid = 1; lu_wa = wa; lu_wd = wd; lu_pc = pc;
  endtask

  initial begin
    idle();
    reset = 1;
    // Reset cycle: outputs forced quiet even with live W and issue.
    wdrv(5'd4, 32'h44); iss(5'd8, 5'd0, 5'd0, 0);
    settle();
    chk("rst_grf_we", 32'(grf_we), 0);
    chk("rst_lu_ready", 32'(lu_ready), 0);
    chk("rst_stall", 32'(iss_stall), 0);
    tick(); tick();
    reset = 0; idle(); iss(5'd8, 5'd0, 5'd0, 0);
    settle();
    chk("post_rst_lu_ready", 32'(lu_ready), 1);
    chk("post_rst_grf_we", 32'(grf_we), 0);
    chk("post_rst_stall", 32'(iss_stall), 0);

    // 1: LU-only write of r8 after a long issue.
    tick(); idle(); iss(5'd1, 5'd2, 5'd8, 1);
    settle(); chk("t1_issue_stall", 32'(iss_stall), 0);
    tick(); idle(); iss(5'd8, 5'd0, 5'd0, 0); lu(5'd8, 32'h1234, 32'h100);
    settle();
    chk("t1_busy8_stall", 32'(iss_stall), 1);
    chk("t1_no_bypass", 32'(grf_we), 0);
    chk("t1_lu_ready", 32'(lu_ready), 1);
    tick(); idle(); iss(5'd8, 5'd0, 5'd0, 0);
    settle();
    chk("t1_grf_we", 32'(grf_we), 1);
    chk("t1_grf_wa", 32'(grf_wa), 8);
    chk("t1_grf_wd", grf_wd, 32'h1234);
    chk("t1_grf_pc", grf_pc, 32'h100);
    chk("t1_drain_bubble", 32'(iss_stall), 1);
    tick(); settle();
    chk("t1_after_grf_we", 32'(grf_we), 0);
    chk("t1_after_stall", 32'(iss_stall), 0);

    // 2: RAW on rt=10 stalls until one cycle after its drain.
    tick(); idle(); iss(5'd1, 5'd2, 5'd10, 1);
    settle(); chk("t2_issue_stall", 32'(iss_stall), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); iss(5'd3, 5'd10, 5'd0, 0);
      settle(); chk("t2_raw_stall", 32'(iss_stall), 1);
    end
    tick(); lu(5'd10, 32'hAA, 32'h104);
    settle();
    chk("t2_push_stall", 32'(iss_stall), 1);
    chk("t2_push_grf_we", 32'(grf_we), 0);
    tick(); lu_valid = 0;
    settle();
    chk("t2_drain_wa", 32'(grf_wa), 10);
    chk("t2_drain_stall", 32'(iss_stall), 1);
    tick(); settle();
    chk("t2_release_stall", 32'(iss_stall), 0);

    // 3: starvation behind continuous W writes forces a front-end stall.
    tick(); idle(); wdrv(5'd20, 32'h0); iss(5'd1, 5'd2, 5'd0, 0); lu(5'd9, 32'h99, 32'h200);
    settle();
    chk("t3_w_wins_we", 32'(grf_we), 1);
    chk("t3_w_wins_wa", 32'(grf_wa), 20);
    chk("t3_w_wins_wd", grf_wd, 32'h0);
    chk("t3_c0_stall", 32'(iss_stall), 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); lu_valid = 0; wdrv(5'd20, 32'(i));
      settle();
      chk("t3_wait_wa", 32'(grf_wa), 20);
      chk("t3_wait_stall", 32'(iss_stall), 0);
    end
    tick(); iss_valid = 0; wdrv(5'd20, 32'h5);
    settle(); chk("t3_force_stall", 32'(iss_stall), 1);
    tick(); wdrv(5'd20, 32'h6);
    settle(); chk("t3_force_hold", 32'(iss_stall), 1);
    tick(); w_we = 0;
    settle();
    chk("t3_drain_we", 32'(grf_we), 1);
    chk("t3_drain_wa", 32'(grf_wa), 9);
    chk("t3_drain_wd", grf_wd, 32'h99);
    chk("t3_drain_pc", grf_pc, 32'h200);
    chk("t3_drain_stall", 32'(iss_stall), 1);
    tick(); iss(5'd1, 5'd2, 5'd0, 0);
    settle();
    chk("t3_idle_we", 32'(grf_we), 0);
    chk("t3_idle_stall", 32'(iss_stall), 0);

    // 4: FIFO full back-pressure and in-order drain.
    tick(); idle(); wdrv(5'd21, 32'h10); lu(5'd11, 32'hB1, 32'h300);
    settle(); chk("t4_ready0", 32'(lu_ready), 1);
    tick(); wdrv(5'd21, 32'h11); lu(5'd12, 32'hB2, 32'h304);
    settle(); chk("t4_ready1", 32'(lu_ready), 1);
    tick(); wdrv(5'd21, 32'h12); lu(5'd13, 32'hB3, 32'h308);
    settle(); chk("t4_full", 32'(lu_ready), 0);
    tick(); w_we = 0;
    settle();
    chk("t4_full_hold", 32'(lu_ready), 0);
    chk("t4_first_wa", 32'(grf_wa), 11);
    chk("t4_first_wd", grf_wd, 32'hB1);
    tick(); wdrv(5'd21, 32'h13);
    settle();
    chk("t4_ready_again", 32'(lu_ready), 1);
    chk("t4_w_wa", 32'(grf_wa), 21);
    tick(); idle();
    settle();
    chk("t4_second_wa", 32'(grf_wa), 12);
    chk("t4_second_pc", grf_pc, 32'h304);
    tick(); settle();
    chk("t4_third_we", 32'(grf_we), 1);
    chk("t4_third_wa", 32'(grf_wa), 13);
    chk("t4_third_wd", grf_wd, 32'hB3);
    tick(); settle();
    chk("t4_empty_we", 32'(grf_we), 0);

    // 5: writes to r0 from either side never reach the GRF.
    tick(); idle(); lu(5'd0, 32'hDEAD, 32'h400); wdrv(5'd0, 32'h55);
    settle();
    chk("t5_zero_we", 32'(grf_we), 0);
    chk("t5_zero_ready", 32'(lu_ready), 1);
    tick(); idle(); iss(5'd0, 5'd0, 5'd0, 0);
    settle();
    chk("t5_dropped_we", 32'(grf_we), 0);
    chk("t5_zero_stall", 32'(iss_stall), 0);

    // 6: reset while the FIFO holds two entries and r3/r5 are pending.
    tick(); idle(); iss(5'd1, 5'd2, 5'd3, 1);
    tick(); idle(); iss(5'd1, 5'd2, 5'd5, 1);
    tick(); idle(); wdrv(5'd22, 32'h20); lu(5'd3, 32'hC3, 32'h500);
    tick(); wdrv(5'd22, 32'h21); lu(5'd5, 32'hC5, 32'h504);
    tick(); lu_valid = 0; wdrv(5'd22, 32'h22); iss(5'd3, 5'd0, 5'd0, 0);
    settle();
    chk("t6_full", 32'(lu_ready), 0);
    chk("t6_busy3", 32'(iss_stall), 1);
    reset = 1;
    settle();
    chk("t6_rst_we", 32'(grf_we), 0);
    chk("t6_rst_stall", 32'(iss_stall), 0);
    tick();
    reset = 0; idle(); iss(5'd3, 5'd5, 5'd0, 0);
    settle();
    chk("t6_flushed_we", 32'(grf_we), 0);
    chk("t6_ready", 32'(lu_ready), 1);
    chk("t6_busy_clear", 32'(iss_stall), 0);
    tick(); settle();
    chk("t6_still_empty", 32'(grf_we), 0);
    chk("t6_idle_stall", 32'(iss_stall), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
